// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the chunked UART receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int BITS_PER_BYTE = 6;
  localparam int DEF_CLKS_PER_BIT = 10417;
endpackage

// File: rtl/uart_chunk_rx_if.sv
// uart_chunk_rx_if: serial input and word/strobe outputs of the chunk receiver
interface uart_chunk_rx_if #(parameter int N = 30);
  logic rxD;
  logic [N:1] data;
  logic signal;
  logic [9:0] counter;
  logic frame_err;
  modport master (output rxD, input data, signal, counter, frame_err);
  modport slave (input rxD, output data, signal, counter, frame_err);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 2-FF input synchronizer and 8N1 byte FSM
module uart_byte_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxD,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       idle
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  logic [1:0] sync;
  logic rx_s;
  rx_state_t st;
  logic [TW-1:0] tmr;
  logic [2:0] nbit;
  logic [7:0] sh;
  assign rx_s = sync[1];
  assign idle = st == IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= 2'b11;
      st <= IDLE;
      tmr <= '0;
      nbit <= '0;
      sh <= '0;
      byte_valid <= 1'b0;
      rx_byte <= '0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], rxD};
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      tmr <= tmr + 1'b1;
      case (st)
        IDLE: begin
          tmr <= '0;
          if (!rx_s) st <= START;
        end
        START: if (tmr == TW'(CLKS_PER_BIT / 2)) begin
          tmr <= '0;
          nbit <= '0;
          st <= rx_s ? IDLE : DATA;
        end
        DATA: if (tmr == TW'(CLKS_PER_BIT - 1)) begin
          tmr <= '0;
          sh <= {rx_s, sh[7:1]};
          nbit <= nbit + 1'b1;
          if (nbit == 3'd7) st <= STOP;
        end
        STOP: if (tmr == TW'(CLKS_PER_BIT - 1)) begin
          st <= IDLE;
          byte_valid <= rx_s;
          frame_err <= !rx_s;
          rx_byte <= sh;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: rtl/uart_chunk_rx.sv
// uart_chunk_rx: packs the 6 low bits of received UART bytes into N-bit words
module uart_chunk_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int N = 30,
  parameter int STROBE_CYCLES = 4,
  parameter int TIMEOUT_BITS = 64
) (
  input logic clk,
  input logic reset_n,
  uart_chunk_rx_if.slave bus
);
  localparam int W = N / BITS_PER_BYTE;
  localparam int IW = $clog2(W + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int OW = $clog2(TO + 2);
  logic byte_valid, idle, done, armed, timeout;
  logic [7:0] rx_byte;
  logic [IW-1:0] idx;
  logic [N:1] shadow, nxt;
  logic [SW-1:0] scnt;
  logic [OW-1:0] tcnt;
  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .reset_n(reset_n),
    .rxD(bus.rxD),
    .byte_valid(byte_valid),
    .rx_byte(rx_byte),
    .frame_err(bus.frame_err),
    .idle(idle)
  );
  assign nxt = (shadow << BITS_PER_BYTE) | N'(rx_byte[5:0]);
  assign done = byte_valid && idx == IW'(W - 1);
  // partial-word timeout only runs while the byte FSM waits for a start bit
  assign armed = TIMEOUT_BITS != 0 && idx != '0 && idle;
  assign timeout = armed && tcnt == OW'(TO - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      idx <= '0;
      shadow <= '0;
      scnt <= '0;
      tcnt <= '0;
      bus.data <= '0;
      bus.signal <= 1'b0;
      bus.counter <= '0;
    end else begin
      tcnt <= armed && !timeout ? tcnt + 1'b1 : '0;
      if (bus.frame_err || timeout) idx <= '0;
      if (timeout) shadow <= '0;
      if (byte_valid) begin
        shadow <= nxt;
        idx <= done ? '0 : idx + 1'b1;
      end
      if (done) begin
        bus.data <= nxt;
        bus.counter <= bus.counter + 1'b1;
        bus.signal <= 1'b1;
        scnt <= SW'(STROBE_CYCLES - 1);
      end else if (scnt != '0) scnt <= scnt - 1'b1;
      else bus.signal <= 1'b0;
    end
endmodule

// File: doc/uart_chunk_rx.md
Name: uart_chunk_rx

Overview:
- Upstream front-end of the pattern-matching pipeline: an 8N1 UART receiver that packs the 6 low bits of each received byte into an N-bit word.
- Presents each completed word on `data` with a fixed-length `signal` strobe; the pattern-matching control unit advances on the strobe's falling edge.
- Also provides a received-word `counter` and a framing-error pulse.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); must be ≥ 4.
- N, 30, output word width; must be a multiple of 6.
- STROBE_CYCLES, 4, cycles `signal` is held high per completed word; must be ≥ 1.
- TIMEOUT_BITS, 64, idle bit-times after which a partial word is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rxD  in  1  UART serial line, idles high
- data  out  N  last completed word, indexed [N:1]; first byte of the word occupies [N:N-5]
- signal  out  1  word strobe
- counter  out  10  completed-word count; wraps modulo 1024
- frame_err  out  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset: one clock domain (`clk`); `reset_n` is asynchronous and active-low. On assertion, all state clears immediately, including mid-byte or mid-word:
  - `data` = 0, `signal` = 0, `counter` = 0, `frame_err` = 0;
  - synchronizer flops = 1, byte index = 0, FSM = IDLE.
- Input sync: `rxD` passes through a 2-FF synchronizer; everything below uses the synchronized value `rx_s`.
- Byte FSM:
  - IDLE: on `rx_s` = 0, go to START and clear the bit timer.
  - START: at timer = CLKS_PER_BIT/2 (integer division), sample the line. If `rx_s` = 1, it was a glitch: return to IDLE with no output. Otherwise go to DATA with the timer cleared.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, the byte is accepted. If 0, pulse `frame_err` for 1 cycle, drop the byte and clear the word byte-index. Either way return to IDLE in the same cycle, so back-to-back frames are received.
- Word assembly:
  - Each accepted byte shifts into a shadow register: `shadow <= {shadow[N-6:1], byte[5:0]}`. Byte bits [7:6] are ignored.
  - The byte index counts 0 to N/6-1.
  - On the final byte, the cycle after the stop-bit sample:
    - `data <= {shadow[N-6:1], byte[5:0]}`;
    - `counter` increments (1023 → 0);
    - `signal` rises and stays high exactly STROBE_CYCLES cycles;
    - the byte index returns to 0.
- `data` holds its value until the next word completes. Downstream reads it at any time after `signal` falls.
- Strobe restart: if a word completes while `signal` is still high, `data` updates and the strobe count reloads to STROBE_CYCLES.
- Timeout (TIMEOUT_BITS > 0):
  - Armed only while the byte index ≠ 0 and the FSM is in IDLE; counts idle clk cycles.
  - At TIMEOUT_BITS × CLKS_PER_BIT cycles, the byte index and shadow clear. No strobe is produced.
  - Any start edge resets the timeout count.
- Simultaneous events: `frame_err` and timeout cannot coincide, because the timeout only runs in IDLE. Reset dominates everything.

Decomposition:
- Shared package `uart_pkg`: FSM state encoding (IDLE/START/DATA/STOP), BITS_PER_BYTE = 6, and the default CLKS_PER_BIT constant.
- Sub-module `uart_byte_rx`: synchronizer plus byte FSM. Outputs `byte_valid` (1-cycle pulse), `byte[7:0]` and `frame_err`.
- Top level: word assembly, strobe, counter and timeout logic.

Test Plan (CLKS_PER_BIT = 16, N = 30, STROBE_CYCLES = 4, TIMEOUT_BITS = 64):
- Bytes 0x24, 0x00, 0x00, 0x00, 0x01 → one cycle after the last stop sample: `data` = 30'h24000001, `data[30:28]` = 3'b100, `signal` high exactly 4 cycles, `counter` = 1, `frame_err` never asserted.
- Bytes 0x3F, 0x15, then a byte with stop bit 0 → `frame_err` pulses 1 cycle, no `signal`, `counter` unchanged. Then 0xFF, 0x00, 0x00, 0x00, 0x2A → `data` = 30'h3F00002A (bits [7:6] of 0xFF ignored), `counter` +1.
- `rxD` low for 3 cycles then high (glitch shorter than a half bit) → no byte accepted, no `frame_err`. A following valid 5-byte word is still received correctly.
- Two bytes, then line idle ≥ 1024 cycles → partial word discarded. Next bytes 0x01, 0x02, 0x03, 0x04, 0x05 → `data` = 30'h01083105, `signal` 4 cycles.
- `reset_n` low during the 3rd byte → `signal`, `data`, `counter` and `frame_err` are 0 in the same cycle (before the next clk edge). After release, a full 5-byte word is received correctly and `counter` = 1.
- 1024 consecutive words → `counter` wraps to 0 after the 1024th `signal`. Every strobe is exactly 4 cycles wide and `data` is stable between strobes.
